// File: rtl/chip8_pkg.sv
//==============================================================================
// Module : chip8_pkg
// Shared VGA 640x480@60 timing constants and RGB444 colour type.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package chip8_pkg;

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_TOTAL      = 10'd525;

    localparam int CHIP8_COLS = 64;
    localparam int CHIP8_ROWS = 32;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

`default_nettype wire

// File: rtl/vga_timing.sv
//==============================================================================
// Module : vga_timing
// Pixel-rate divider, h/v scan counters and raw (unregistered) sync/visible.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module vga_timing
    import chip8_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       pix_tick_o,
    output logic [9:0] h_o,
    output logic [9:0] v_o,
    output logic       hs_o,
    output logic       vs_o,
    output logic       visible_o
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             tick;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (h_q == H_TOTAL - 10'd1) begin
                h_d = '0;
                v_d = (v_q == V_TOTAL - 10'd1) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign pix_tick_o = tick;
    assign h_o        = h_q;
    assign v_o        = v_q;
    assign hs_o       = !((h_q >= H_SYNC_START) && (h_q <= H_SYNC_END));
    assign vs_o       = !((v_q >= V_SYNC_START) && (v_q <= V_SYNC_END));
    assign visible_o  = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);

endmodule

`default_nettype wire

// File: rtl/chip8_vga_scan.sv
//==============================================================================
// Module : chip8_vga_scan
// Scales the 64x32 Chip8 framebuffer 10x to 640x480 VGA via a per-frame shadow.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module chip8_vga_scan
    import chip8_pkg::*;
#(
    parameter int          CLK_DIV  = 4,
    parameter int          SCALE    = 10,
    parameter int          Y_OFFSET = 80,
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic          SYS_CLK,
    input  logic          RST,
    input  logic [0:2047] vidin,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic [3:0]    VGA_R,
    output logic [3:0]    VGA_G,
    output logic [3:0]    VGA_B,
    output logic          frame_latch,
    output logic          pix_tick
);

    localparam int            SC_W    = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCALE - 1);
    localparam logic [9:0]    IMG_TOP = 10'(Y_OFFSET);
    localparam logic [9:0]    IMG_BOT = 10'(Y_OFFSET + CHIP8_ROWS * SCALE);

    logic          tick;
    logic [9:0]    h, v;
    logic          hs_raw, vs_raw, visible;

    vga_timing #(
        .CLK_DIV (CLK_DIV)
    ) u_timing (
        .clk_i      (SYS_CLK),
        .rst_i      (RST),
        .pix_tick_o (tick),
        .h_o        (h),
        .v_o        (v),
        .hs_o       (hs_raw),
        .vs_o       (vs_raw),
        .visible_o  (visible)
    );

    logic [SC_W-1:0] xs_q, xs_d, ys_q, ys_d;
    logic [5:0]      col_q, col_d;
    logic [4:0]      row_q, row_d;
    logic [0:2047]   shadow_q;
    logic            hs_q, vs_q;
    rgb444_t         rgb_q, rgb_d;

    logic line_end, in_rows, in_img, pix_on, load;

    assign line_end = tick && (h == H_TOTAL - 10'd1);
    assign in_rows  = (v >= IMG_TOP) && (v < IMG_BOT);
    assign in_img   = (h < H_VISIBLE) && in_rows;
    assign pix_on   = shadow_q[{row_q, col_q}];
    assign load     = tick && (h == 10'd0) && (v == V_VISIBLE);

    // Sub-counters are zeroed on the step into h==0 / v==IMG_TOP, so they
    // already read 0 while the scan sits on those positions.
    always_comb begin
        xs_d  = xs_q;
        col_d = col_q;
        ys_d  = ys_q;
        row_d = row_q;
        if (line_end) begin
            xs_d  = '0;
            col_d = '0;
            if (in_rows) begin
                if (ys_q == SC_LAST) begin
                    ys_d  = '0;
                    row_d = row_q + 5'd1;
                end else begin
                    ys_d = ys_q + 1'b1;
                end
            end else begin
                ys_d  = '0;
                row_d = '0;
            end
        end else if (tick && (h < H_VISIBLE)) begin
            if (xs_q == SC_LAST) begin
                xs_d  = '0;
                col_d = col_q + 6'd1;
            end else begin
                xs_d = xs_q + 1'b1;
            end
        end
    end

    always_comb begin
        rgb_d = '0;
        if (visible) begin
            rgb_d = (in_img && pix_on) ? rgb444_t'(FG_COLOR) : rgb444_t'(BG_COLOR);
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            xs_q     <= '0;
            col_q    <= '0;
            ys_q     <= '0;
            row_q    <= '0;
            shadow_q <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            rgb_q    <= '0;
        end else begin
            xs_q  <= xs_d;
            col_q <= col_d;
            ys_q  <= ys_d;
            row_q <= row_d;
            if (load) begin
                shadow_q <= vidin;
            end
            if (tick) begin
                hs_q  <= hs_raw;
                vs_q  <= vs_raw;
                rgb_q <= rgb_d;
            end
        end
    end

    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_R       = rgb_q.r;
    assign VGA_G       = rgb_q.g;
    assign VGA_B       = rgb_q.b;
    assign frame_latch = load;
    assign pix_tick    = tick;

endmodule

`default_nettype wire

// File: tb/tb_chip8_vga_scan.sv
//==============================================================================
// Module : tb_chip8_vga_scan
// Scoreboard bench: expected pixels queued by position, popped by a monitor.
// Rev    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_chip8_vga_scan;

    localparam int LINE  = 800;
    localparam int FRAME = 800 * 525;

    logic          SYS_CLK = 1'b0;
    logic          RST     = 1'b1;
    logic [0:2047] vidin;
    logic          VGA_HS, VGA_VS, frame_latch, pix_tick;
    logic [3:0]    VGA_R, VGA_G, VGA_B;

    chip8_vga_scan #(
        .CLK_DIV  (4),
        .SCALE    (10),
        .Y_OFFSET (80),
        .FG_COLOR (12'hFFF),
        .BG_COLOR (12'h000)
    ) dut (
        .SYS_CLK     (SYS_CLK),
        .RST         (RST),
        .vidin       (vidin),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .frame_latch (frame_latch),
        .pix_tick    (pix_tick)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    typedef struct {
        int         ep;
        int         idx;
        logic [11:0] rgb;
        logic       hs;
        logic       vs;
    } item_t;

    item_t sb[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0, k = 0, epoch = 0, rst_cyc = 0;
    logic  rst_prev = 1'b0;

    // k = SYS_CLK edges since the last reset edge; outputs after edge k (k%4==0)
    // describe scan position k/4-1.
    always @(posedge SYS_CLK) begin
        cyc++;
        if (RST) begin
            if (!rst_prev) epoch++;
            k       = 0;
            rst_cyc = cyc;
        end else begin
            k++;
        end
        rst_prev = RST;
    end

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic void push(input int ep, input int f, input int v, input int h,
                                 input logic [11:0] rgb);
        item_t it;
        it.ep  = ep;
        it.idx = f * FRAME + v * LINE + h;
        it.rgb = rgb;
        it.hs  = !(h >= 656 && h <= 751);
        it.vs  = !(v >= 490 && v <= 491);
        sb.push_back(it);
    endfunction

    // Monitor
    always @(negedge SYS_CLK) begin
        int    n;
        item_t it;
        if (!RST && k > 0 && (k % 4) == 0) begin
            n = k / 4 - 1;
            while (sb.size() > 0 && (sb[0].ep < epoch || (sb[0].ep == epoch && sb[0].idx < n))) begin
                it = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL scan_missed ep=%0d idx=%0d never presented", it.ep, it.idx);
            end
            if (sb.size() > 0 && sb[0].ep == epoch && sb[0].idx == n) begin
                it = sb.pop_front();
                checks++;
                if ({VGA_R, VGA_G, VGA_B} !== it.rgb || VGA_HS !== it.hs || VGA_VS !== it.vs) begin
                    errors++;
                    $display("FAIL scan ep=%0d f=%0d v=%0d h=%0d rgb=%h req=%h hs=%b req=%b vs=%b req=%b",
                             it.ep, n / FRAME, (n % FRAME) / LINE, n % LINE,
                             {VGA_R, VGA_G, VGA_B}, it.rgb, VGA_HS, it.hs, VGA_VS, it.vs);
                end
            end
        end
    end

    // Edge timing measurement
    logic hs_p = 1'b1, vs_p = 1'b1, fl_p = 1'b0;
    int   hf[$], hr[$], vf[$], vr[$], fl[$];
    int   fl_wide = 0, fl_first = -1, hs_first = -1, hs_after = -1;

    always @(negedge SYS_CLK) begin
        if (epoch == 1 && !RST) begin
            if (hs_p && !VGA_HS && hf.size() < 2) hf.push_back(cyc);
            if (hs_first < 0 && hs_p && !VGA_HS) hs_first = cyc - rst_cyc;
            if (!hs_p && VGA_HS && hr.size() < 1) hr.push_back(cyc);
            if (vs_p && !VGA_VS && vf.size() < 2) vf.push_back(cyc);
            if (!vs_p && VGA_VS && vr.size() < 1) vr.push_back(cyc);
            if (frame_latch && !fl_p) begin
                if (fl.size() == 0) fl_first = cyc - rst_cyc;
                fl.push_back(cyc);
            end
            if (frame_latch && fl_p) fl_wide++;
        end else if (epoch == 2 && !RST && hs_after < 0 && hs_p && !VGA_HS) begin
            hs_after = cyc - rst_cyc;
        end
        hs_p = VGA_HS;
        vs_p = VGA_VS;
        fl_p = frame_latch;
    end

    task automatic wait_pos(input int ep, input int f, input int v, input int h);
        int target;
        int guard;
        target = f * FRAME + v * LINE + h;
        guard  = 0;
        while (!(epoch == ep && k >= 4 * (target + 1))) begin
            @(negedge SYS_CLK);
            guard++;
            if (guard > 7_000_000) begin
                $display("FAIL wait_pos timeout ep=%0d idx=%0d", ep, target);
                $fatal(1);
            end
        end
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_pt;
        logic [11:0] e;
        exp_pt = 8'b0100_0100;

        vidin       = '0;
        vidin[0]    = 1'b1;
        vidin[2047] = 1'b1;
        RST         = 1'b1;

        // frame 0: shadow still empty; sync edges
        push(1, 0, 80, 0, 12'h000);
        push(1, 0, 100, 655, 12'h000);
        push(1, 0, 100, 656, 12'h000);
        push(1, 0, 100, 751, 12'h000);
        push(1, 0, 100, 752, 12'h000);
        push(1, 0, 489, 799, 12'h000);
        push(1, 0, 490, 0, 12'h000);
        push(1, 0, 491, 799, 12'h000);
        push(1, 0, 492, 0, 12'h000);
        // frame 1: top-left and bottom-right pixels, held across the v=200 toggle
        for (int v = 78; v <= 91; v++)
            for (int h = 0; h <= 11; h++) begin
                e = (v >= 80 && v <= 89 && h <= 9) ? 12'hFFF : 12'h000;
                push(1, 1, v, h, e);
            end
        push(1, 1, 250, 300, 12'h000);
        for (int v = 388; v <= 401; v++)
            for (int h = 628; h <= 641; h++) begin
                e = (v >= 390 && v <= 399 && h >= 630 && h <= 639) ? 12'hFFF : 12'h000;
                push(1, 1, v, h, e);
            end
        push(1, 1, 479, 639, 12'h000);
        // frame 2: all ones
        push(1, 2, 0, 5, 12'h000);
        push(1, 2, 79, 320, 12'h000);
        push(1, 2, 80, 0, 12'hFFF);
        push(1, 2, 80, 639, 12'hFFF);
        push(1, 2, 100, 640, 12'h000);
        push(1, 2, 100, 799, 12'h000);
        push(1, 2, 240, 320, 12'hFFF);
        push(1, 2, 399, 0, 12'hFFF);
        push(1, 2, 399, 639, 12'hFFF);
        push(1, 2, 400, 0, 12'h000);
        push(1, 2, 400, 320, 12'h000);
        push(1, 2, 479, 639, 12'h000);
        push(1, 2, 485, 100, 12'h000);
        // frame 3 up to the mid-frame reset
        push(1, 3, 299, 639, 12'hFFF);
        push(1, 3, 300, 399, 12'hFFF);
        // after reset: shadow cleared
        push(2, 0, 80, 0, 12'h000);
        push(2, 0, 85, 5, 12'h000);
        push(2, 0, 100, 656, 12'h000);
        push(2, 0, 240, 320, 12'h000);

        repeat (10) @(negedge SYS_CLK);
        check("rst_hs", VGA_HS, 1);
        check("rst_vs", VGA_VS, 1);
        check("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        check("rst_latch", frame_latch, 0);
        check("rst_tick", pix_tick, 0);
        RST = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge SYS_CLK);
            check("pix_tick_seq", pix_tick, exp_pt[i]);
        end

        wait_pos(1, 1, 200, 100);
        vidin = '1;

        wait_pos(1, 3, 300, 400);
        RST = 1'b1;
        @(negedge SYS_CLK);
        check("mid_rst_hs", VGA_HS, 1);
        check("mid_rst_vs", VGA_VS, 1);
        check("mid_rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        check("mid_rst_latch", frame_latch, 0);
        check("mid_rst_tick", pix_tick, 0);
        RST = 1'b0;

        wait_pos(2, 0, 241, 0);

        check("hs_first_fall", hs_first, 2628);
        check("hs_period", (hf.size() > 1) ? hf[1] - hf[0] : -1, 3200);
        check("hs_width", (hf.size() > 0 && hr.size() > 0) ? hr[0] - hf[0] : -1, 384);
        check("vs_period", (vf.size() > 1) ? vf[1] - vf[0] : -1, 1680000);
        check("vs_width", (vf.size() > 0 && vr.size() > 0) ? vr[0] - vf[0] : -1, 6400);
        check("latch_count", fl.size(), 3);
        check("latch_first", fl_first, 1536003);
        check("latch_period1", (fl.size() > 1) ? fl[1] - fl[0] : -1, 1680000);
        check("latch_period2", (fl.size() > 2) ? fl[2] - fl[1] : -1, 1680000);
        check("latch_width", fl_wide, 0);
        check("hs_after_reset", hs_after, 2628);

        while (sb.size() > 0) begin
            item_t it;
            it = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL scan_leftover ep=%0d idx=%0d", it.ep, it.idx);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/chip8_vga_scan.md
# chip8_vga_scan

Downstream display stage for the Chip8 core. Consumes the core's 64×32 monochrome framebuffer (flat 2048-bit vector, row-major, bit 0 = top-left pixel) and produces 640×480 at 60 Hz VGA for the board connector. Each Chip8 pixel is scaled to a 10×10 screen block and the 320-line image is centred vertically. A shadow copy of the framebuffer is taken once per frame at the start of vertical blank, so the display never tears.

## Interface
- `CLK_DIV`, 4: SYS_CLK cycles per VGA pixel (100 MHz in, 25 MHz pixel rate).
- `SCALE`, 10: screen pixels per Chip8 pixel, in both axes.
- `Y_OFFSET`, 80: blank lines above the image.
- `FG_COLOR`, 12'hFFF: RGB444 colour of lit pixels.
- `BG_COLOR`, 12'h000: RGB444 colour of unlit pixels and the border.

Ports (one clock; reset is synchronous and active-high):
- `SYS_CLK`  in  1  system clock.
- `RST`  in  1  synchronous active-high reset.
- `vidin`  in  [0:2047]  live framebuffer from the core; pixel (row r, col c) is `vidin[r*64+c]`.
- `VGA_HS`  out  1  horizontal sync, active low.
- `VGA_VS`  out  1  vertical sync, active low.
- `VGA_R`, `VGA_G`, `VGA_B`  out  4 each  colour outputs.
- `frame_latch`  out  1  one-SYS_CLK pulse when the shadow buffer is loaded.
- `pix_tick`  out  1  pixel-rate enable, exported for debug.

## Operation
- Divider: `div` counts 0..CLK_DIV-1. `pix_tick` = (div == CLK_DIV-1). All counters below advance only on `pix_tick`.
- Horizontal counter `h`: 0..799.
  - Visible region 0..639.
  - HS low for h in 656..751.
  - Wraps 799→0 and increments `v`.
- Vertical counter `v`: 0..524.
  - Visible region 0..479.
  - VS low for v in 490..491.
  - Wraps 524→0.
- Scaling uses sub-counters, not division or multiplication.
  - `xs` (0..SCALE-1) and `col` (0..63) advance with `h` inside 0..639. Both reset at h==0.
  - `ys` and `row` (0..31) advance at each line end while v is in Y_OFFSET..Y_OFFSET+319. Both reset at v==Y_OFFSET.
- Image region: h < 640 and Y_OFFSET ≤ v < Y_OFFSET+320. Inside it, colour = `shadow[row*64+col]` ? FG_COLOR : BG_COLOR. Everywhere else visible, colour = BG_COLOR.
- Blanking: outside the visible region, RGB = 0.
- Shadow load: on the `pix_tick` where h==0 and v==480, `shadow <= vidin` and `frame_latch` pulses for that one SYS_CLK.
  - Changes to `vidin` at any other time are invisible until the next load.
  - A `vidin` change on the same cycle as the load is captured.

## Timing
- Reset values:
  - div = 0, h = 0, v = 0.
  - All sub-counters = 0.
  - shadow = all zeros.
  - VGA_HS = 1, VGA_VS = 1.
  - RGB = 0.
  - frame_latch = 0.
  - pix_tick = 0.
- RST asserted mid-frame: every output takes its reset value on the next SYS_CLK edge, and the scan restarts from h=0, v=0.
- Output pipeline: HS, VS and RGB are registered, updated on `pix_tick`, and describe the (h, v) value held before that tick.
  - Latency is exactly one pixel (CLK_DIV SYS_CLK) for all three, so sync and colour stay aligned.
- Line period: 800 × CLK_DIV = 3200 SYS_CLK. HS low for 96 pixels = 384 SYS_CLK.
- Frame period: 525 lines = 1,680,000 SYS_CLK. VS low for 2 lines = 6400 SYS_CLK.
- `frame_latch` occurs once per frame, spaced 1,680,000 SYS_CLK apart.

## Structure
- Shared package `chip8_pkg` holds the VGA timing constants (H_VISIBLE 640, H_SYNC_START 656, H_SYNC_END 751, H_TOTAL 800, V_VISIBLE 480, V_SYNC_START 490, V_SYNC_END 491, V_TOTAL 525) and the RGB444 colour type. The Chip8 top and other display blocks reuse them.
- Sub-module `vga_timing` contains the divider, the h/v counters and sync generation. Its outputs are `pix_tick`, `h`, `v`, raw `hs`/`vs` and `visible`.
- `chip8_vga_scan` itself contains the scaling sub-counters, the shadow buffer, the pixel select and the output registers.

## Test plan
- Reset and raw timing:
  - Hold RST for 10 cycles, then check VGA_HS = VGA_VS = 1, RGB = 0, frame_latch = 0.
  - Run free: HS falling edges are 3200 SYS_CLK apart with a low width of 384; VS falling edges are 1,680,000 apart with a low width of 6400.
- Single pixel: set `vidin[0]` = 1 (all else 0) and wait past one `frame_latch`.
  - RGB = FFF for h 0..9 on v 80..89.
  - RGB = 000 at h 10, and at v 79 and v 90.
- Bottom-right pixel: set `vidin[2047]` = 1.
  - FFF appears only at h 630..639, v 390..399.
- Tear-free update: after a latch, toggle `vidin` to all ones during the visible line v = 200.
  - Output stays BG until v = 480 of that frame.
  - All image-region pixels are FFF in the next frame.
- Border and blanking (all ones loaded):
  - v 0..79 and v 400..479 output BG.
  - h 640..799 outputs RGB = 0.
- Reset mid-frame: assert RST at v = 300, h = 400 for one cycle.
  - Outputs reach reset values on the next edge.
  - The shadow buffer clears, so the image is blank until the next latch.
  - The next HS falling edge occurs 656 × 4 (+4 for the output register) SYS_CLK after RST deasserts.
